// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between requesting agents (master) and the ring arbiter (slave).
interface ring_rr_arbiter_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;
    logic [N-1:0]  ptr;

    modport master (
        output req,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  ptr
    );

    modport slave (
        input  req,
        output grant,
        output grant_valid,
        output grant_id,
        output ptr
    );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer. The grant is registered,
// held while the owner keeps requesting, and rotated after MAX_HOLD cycles under contention.
module ring_rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned IW       = $clog2(N)
) (
    input logic              clk,
    input logic              rstn,
    ring_rr_arbiter_if.slave bus
);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [IW-1:0] ptr_idx;
    logic [N-1:0]  cand;
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] win_prev;
    logic [N-1:0]  win_oh;
    logic [N-1:0]  win_ptr;
    logic          take;

    // Index of the pointer bit; ptr always equals owner-1 (wrapped) after a grant, so
    // one search start serves both IDLE arbitration and release/rotation searches.
    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_q[IW'(i)]) ptr_idx = IW'(i);
        end
    end

    // Downward wrapping search over candidates; the current owner is excluded.
    always_comb begin
        int idx;
        cand  = bus.req & ~grant_q;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_idx) - k + N) % N;
            if (!found && cand[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        win_prev = (win == '0) ? IW'(N - 1) : win - 1'b1;
        win_oh   = {{(N-1){1'b0}}, 1'b1} << win;
        win_ptr  = {{(N-1){1'b0}}, 1'b1} << win_prev;
    end

    // Next-state: idle arbitration, release handover, forced rotation, saturating hold count.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        hold_d  = hold_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) take = 1'b1;
            end
            GRANT: begin
                if (!bus.req[gid_q]) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HW'(MAX_HOLD) && found) begin
                    take = 1'b1;
                end else if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = GRANT;
            grant_d = win_oh;
            gid_d   = win;
            hold_d  = HW'(1);
            ptr_d   = win_ptr;
        end
        valid_d = |grant_d;
    end

    // State registers; pointer resets to bit N-1 so the first search starts at the top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            gid_q   <= '0;
            ptr_q   <= {1'b1, {(N-1){1'b0}}};
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_id    = gid_q;
    assign bus.ptr         = ptr_q;
endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Scoreboard bench for ring_rr_arbiter (N=8, MAX_HOLD=4): directed vectors push expected
// post-edge outputs; a monitor pops and compares after each clock edge or reset assertion.
module tb_ring_rr_arbiter;
    logic clk;
    logic rstn;

    ring_rr_arbiter_if #(.N(8), .IW(3)) bus ();

    ring_rr_arbiter #(.N(8), .MAX_HOLD(4), .IW(3)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] g;
        logic       v;
        logic [2:0] id;
        logic [7:0] p;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string nm, input logic [7:0] g, input logic [7:0] p);
        exp_t e;
        e.name = nm;
        e.g    = g;
        e.v    = |g;
        e.id   = '0;
        for (int i = 0; i < 8; i++) if (g[i]) e.id = 3'(i);
        e.p    = p;
        q.push_back(e);
    endtask

    // Drive req for the coming edge and expect the given outputs after it.
    task automatic cyc(input string nm, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] p);
        bus.req = r;
        push(nm, g, p);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        bus.req = 8'h00;
        #1 rstn = 1'b0;
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    // Monitor: compare outputs shortly after every edge or reset assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rstn);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (bus.grant !== e.g || bus.grant_valid !== e.v || bus.grant_id !== e.id ||
                    bus.ptr !== e.p) begin
                    fails++;
                    $display("FAIL %s: got grant=%h valid=%b id=%0d ptr=%h, want grant=%h valid=%b id=%0d ptr=%h",
                             e.name, bus.grant, bus.grant_valid, bus.grant_id, bus.ptr,
                             e.g, e.v, e.id, e.p);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] gseq [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
        logic [7:0] pseq [9] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80, 8'h40};

        bus.req = 8'h00;
        rstn    = 1'b1;
        #1 rstn = 1'b0;
        #2;
        push("reset", 8'h00, 8'h80);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cyc("idle_after_reset", 8'h00, 8'h00, 8'h80);

        // Single requester 3, then release.
        cyc("single_grant", 8'h08, 8'h08, 8'h04);
        cyc("single_hold", 8'h08, 8'h08, 8'h04);
        cyc("single_hold", 8'h08, 8'h08, 8'h04);
        cyc("single_release", 8'h00, 8'h00, 8'h04);
        cyc("single_idle", 8'h00, 8'h00, 8'h04);

        // Full contention: each owner holds exactly 4 cycles, ptr wraps 01 -> 80.
        do_reset();
        for (int s = 0; s < 9; s++)
            for (int c = 0; c < 4; c++) cyc("contention", 8'hFF, gseq[s], pseq[s]);
        cyc("contention_drop", 8'h00, 8'h00, 8'h40);

        // Early release of owner 5 hands straight to requester 2.
        do_reset();
        cyc("early_grant", 8'h24, 8'h20, 8'h10);
        cyc("early_hold", 8'h24, 8'h20, 8'h10);
        cyc("early_hold", 8'h24, 8'h20, 8'h10);
        cyc("early_handover", 8'h04, 8'h04, 8'h02);
        cyc("early_next_hold", 8'h04, 8'h04, 8'h02);
        cyc("early_idle", 8'h00, 8'h00, 8'h02);

        // Owner 1 releases; search order 0,7,6 picks 7.
        cyc("wrap_grant1", 8'h02, 8'h02, 8'h01);
        cyc("wrap_hold1", 8'hC2, 8'h02, 8'h01);
        cyc("wrap_handover", 8'hC0, 8'h80, 8'h40);
        cyc("wrap_release7", 8'h00, 8'h00, 8'h40);

        // Async reset while requester 4 owns the grant.
        cyc("pre_async_grant", 8'h10, 8'h10, 8'h08);
        cyc("pre_async_hold", 8'h10, 8'h10, 8'h08);
        push("async_reset", 8'h00, 8'h80);
        #1 rstn = 1'b0;
        #3;
        bus.req = 8'hFF;
        rstn    = 1'b1;
        cyc("post_reset_first", 8'hFF, 8'h80, 8'h40);
        cyc("post_reset_hold", 8'hFF, 8'h80, 8'h40);

        repeat (4) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares a single resource among N requesters, using an N-bit one-hot ring pointer as its rotating priority token. The pointer advances with the same shift-right-with-wrap step as the team's 8-bit ring counter, so bit N-1 wraps after bit 0. The block sits between requesting agents and a shared datapath. It issues a registered one-hot grant, holds that grant while the owner keeps requesting, and forces rotation after MAX_HOLD cycles when another requester is waiting.

## Interface
- N, default 8: number of requesters; N >= 2.
- MAX_HOLD, default 4: maximum consecutive grant cycles while another requester waits; MAX_HOLD >= 1.
- IW, default $clog2(N): width of grant_id.
- clk  input  1  rising-edge clock.
- rstn  input  1  reset, asynchronous, active-low.
- req  input  N  request vector; bit i = requester i.
- grant  output  N  registered one-hot grant, or all-zero.
- grant_valid  output  1  equals |grant.
- grant_id  output  IW  index of the set grant bit; 0 when grant_valid=0.
- ptr  output  N  one-hot priority pointer: the position searched first.

## Operation
- Reset (async, immediate): grant=0, grant_valid=0, grant_id=0, ptr = one-hot bit N-1 (8'h80 for N=8), hold_cnt=0, state=IDLE.
- Search function: take candidates = req & ~grant. Scan from the pointer position downward (i, i-1, …, 0, N-1, …) and return the first set bit. If there is none, return "no winner".
- IDLE (grant=0) on each edge:
  - req==0: stay in IDLE.
  - Otherwise: grant <= winner of the search starting at ptr; hold_cnt <= 1; go to GRANT.
- GRANT (owner = set bit of grant) on each edge. Priority order:
  1. req[owner]==0 is a release. Search starting at owner-1 (wrapping to N-1 after 0).
     - Winner found: grant <= winner, hold_cnt <= 1, no bubble.
     - No winner: grant <= 0, go to IDLE.
  2. hold_cnt==MAX_HOLD and (req & ~grant)!=0 is a forced rotation. Switch to the winner of the same search; hold_cnt <= 1.
  3. Otherwise keep grant; hold_cnt <= min(hold_cnt+1, MAX_HOLD). The counter saturates, so an uncontended owner holds indefinitely.
- ptr update: on every edge where grant changes to a new nonzero owner w, ptr <= one-hot of w rotated right by one. Owner 0 gives ptr = bit N-1. ptr is unchanged on all other edges, including the return to IDLE.
- grant_id and grant_valid are registered together with grant; they are never combinational from req.
- The owner's own request is never a candidate on a switch, so the owner cannot re-win in the same edge.

## Timing
- Latency, req to grant: 1 cycle. A request sampled at edge k produces grant visible after edge k.
- Release: the owner still sees grant asserted during the cycle in which it dropped req. The grant moves or clears at the next edge.
- Handover is back-to-back. The next owner's grant follows the previous owner's last grant cycle with no idle cycle.
- Forced rotation: under continuous contention each owner holds exactly MAX_HOLD cycles.
- A new request arriving on the same edge as a release is a valid candidate in that search.
- rstn assertion mid-grant clears all outputs asynchronously, with no wait for clk. After deassertion, the first grant is searched from bit N-1.

## Test plan
- Reset check, N=8:
  - Stimulus: hold rstn=0.
  - Response: grant=8'h00, grant_valid=0, grant_id=0, ptr=8'h80.
  - Then release rstn with req=0 for 3 cycles: all outputs unchanged.
- Single request, N=8:
  - Stimulus: req=8'h08 sampled at edge k.
  - Response: after edge k, grant=8'h08, grant_id=3, ptr=8'h04.
  - Then req=0 at edge k+3: grant=0 after k+3, ptr stays 8'h04.
- Full contention, N=8, MAX_HOLD=4:
  - Stimulus: req=8'hFF held.
  - Response: grant sequence 80,40,20,10,08,04,02,01,80, each value held exactly 4 cycles.
  - ptr wraps from 8'h01 to 8'h80 at the 0→7 handover.
- Early release without bubble:
  - Stimulus: req[5] and req[2] rise together from IDLE with ptr=8'h80; req[5] drops after 2 granted cycles.
  - Response: grant 8'h20 for 3 cycles (the last one with req low), then 8'h04 on the very next cycle.
- Wrap search:
  - Stimulus: owner 1 releases while req[7] and req[6] are set.
  - Response: next grant=8'h80 (search order 0,7,6), ptr=8'h40.
- Async reset mid-grant:
  - Stimulus: assert rstn=0 between edges while grant=8'h10.
  - Response: grant=0 and ptr=8'h80 immediately.
  - Then after release with req=8'hFF: first grant=8'h80.
